// File: rtl/mkio_pkg.sv
// Shared types and default timing parameters for the MKIO dual-channel bus arbiter.
package mkio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOCK_A,
    LOCK_B,
    TX,
    HOLD
  } arb_state_t;

  typedef enum logic [1:0] {
    CH_NONE = 2'b00,
    CH_A    = 2'b01,
    CH_B    = 2'b10
  } ch_sel_t;

  localparam int IDLE_TO_DEF    = 64;
  localparam int HOLD_CYC_DEF   = 10;
  localparam int SUPER_CYC_DEF  = 16;
  localparam int BABBLE_CYC_DEF = 25600;

endpackage

// File: rtl/mkio_act_det.sv
// Per-channel line front end: 2-flop synchronizer, activity detect and optional babble fault.
// Babble detection is compiled in only when MKIO_CH_FAULT_EN is defined.
module mkio_act_det
  import mkio_pkg::*;
#(
  parameter int BABBLE_CYC = BABBLE_CYC_DEF
) (
  input  logic clk32,
  input  logic reset,
  input  logic i_di1,
  input  logic i_di0,
  input  logic i_faultClr,
  output logic o_di1,
  output logic o_di0,
  output logic o_active,
  output logic o_fault
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {i_di1, i_di0};
      r_sync <= r_meta;
    end
  end

  assign o_di1    = r_sync[1];
  assign o_di0    = r_sync[0];
  assign o_active = |r_sync;

`ifdef MKIO_CH_FAULT_EN
  localparam int BABBLE_W = $clog2(BABBLE_CYC + 1);
  localparam logic [BABBLE_W-1:0] BABBLE_MAX  = BABBLE_W'(BABBLE_CYC);
  localparam logic [BABBLE_W-1:0] BABBLE_LAST = BABBLE_W'(BABBLE_CYC - 1);

  logic [BABBLE_W-1:0] r_babbleCnt;
  logic                r_fault;

  // Clearing the count with the fault lets a still-busy line start a fresh babble window.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_babbleCnt <= '0;
      r_fault     <= 1'b0;
    end else if (i_faultClr) begin
      r_babbleCnt <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (!o_active) begin
        r_babbleCnt <= '0;
      end else if (r_babbleCnt != BABBLE_MAX) begin
        r_babbleCnt <= r_babbleCnt + BABBLE_W'(1);
      end
      if (o_active && (r_babbleCnt == BABBLE_LAST)) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign o_fault = r_fault;
`else
  logic w_unused;
  assign w_unused = i_faultClr ^ (BABBLE_CYC > 0);
  assign o_fault  = 1'b0;
`endif

endmodule

// File: rtl/mkio_bus_arbiter.sv
// MKIO A/B bus arbiter: locks the receiver onto one active channel and routes transmit to it.
// Define MKIO_CH_FAULT_EN to enable per-channel babble fault detection.
module mkio_bus_arbiter
  import mkio_pkg::*;
#(
  parameter int IDLE_TO    = IDLE_TO_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int SUPER_CYC  = SUPER_CYC_DEF,
  parameter int BABBLE_CYC = BABBLE_CYC_DEF
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       DI1A,
  input  logic       DI0A,
  input  logic       DI1B,
  input  logic       DI0B,
  output logic       DI1,
  output logic       DI0,
  input  logic       DO1,
  input  logic       DO0,
  input  logic       tx_busy,
  output logic       DO1A,
  output logic       DO0A,
  output logic       DO1B,
  output logic       DO0B,
  output logic       TX_INHIBIT_A,
  output logic       TX_INHIBIT_B,
  output logic       RX_STROB_A,
  output logic       RX_STROB_B,
  output logic [1:0] active_ch,
  output logic       abort,
  output logic       ch_fault_a,
  output logic       ch_fault_b,
  input  logic       fault_clr
);

  localparam int IDLE_W  = $clog2(IDLE_TO + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam int SUPER_W = $clog2(SUPER_CYC + 1);

  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_TO);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TO - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [SUPER_W-1:0] SUPER_MAX  = SUPER_W'(SUPER_CYC);
  localparam logic [SUPER_W-1:0] SUPER_LAST = SUPER_W'(SUPER_CYC - 1);

  logic w_di1A, w_di0A, w_actA, w_faultA;
  logic w_di1B, w_di0B, w_actB, w_faultB;

  mkio_act_det #(.BABBLE_CYC(BABBLE_CYC)) u_detA (
    .clk32      (clk32),
    .reset      (reset),
    .i_di1      (DI1A),
    .i_di0      (DI0A),
    .i_faultClr (fault_clr),
    .o_di1      (w_di1A),
    .o_di0      (w_di0A),
    .o_active   (w_actA),
    .o_fault    (w_faultA)
  );

  mkio_act_det #(.BABBLE_CYC(BABBLE_CYC)) u_detB (
    .clk32      (clk32),
    .reset      (reset),
    .i_di1      (DI1B),
    .i_di0      (DI0B),
    .i_faultClr (fault_clr),
    .o_di1      (w_di1B),
    .o_di0      (w_di0B),
    .o_active   (w_actB),
    .o_fault    (w_faultB)
  );

  arb_state_t          r_state, w_stateNext;
  ch_sel_t             r_lockCh, w_lockChNext;
  logic [IDLE_W-1:0]   r_idleCnt, w_idleCntNext;
  logic [SUPER_W-1:0]  r_superCnt, w_superCntNext;
  logic [HOLD_W-1:0]   r_holdCnt, w_holdCntNext;
  logic                r_abort, w_abortNext;

  logic w_lockA, w_ownAct, w_othAct, w_ownFault, w_othEligible;

  // State is asynchronously reset so the transmit enables drop the instant reset rises.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_lockCh   <= CH_NONE;
      r_idleCnt  <= '0;
      r_superCnt <= '0;
      r_holdCnt  <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_lockCh   <= w_lockChNext;
      r_idleCnt  <= w_idleCntNext;
      r_superCnt <= w_superCntNext;
      r_holdCnt  <= w_holdCntNext;
      r_abort    <= w_abortNext;
    end
  end

  always_comb begin
    w_lockA       = (r_lockCh == CH_A);
    w_ownAct      = w_lockA ? w_actA   : w_actB;
    w_othAct      = w_lockA ? w_actB   : w_actA;
    w_ownFault    = w_lockA ? w_faultA : w_faultB;
    w_othEligible = w_othAct && !(w_lockA ? w_faultB : w_faultA);
  end

  // Priority inside a lock: fault drop, then transmit, then supersede, then idle timeout.
  always_comb begin
    w_stateNext    = r_state;
    w_lockChNext   = r_lockCh;
    w_idleCntNext  = '0;
    w_superCntNext = '0;
    w_holdCntNext  = '0;
    w_abortNext    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_actA && !w_faultA) begin
          w_stateNext  = LOCK_A;
          w_lockChNext = CH_A;
        end else if (w_actB && !w_faultB) begin
          w_stateNext  = LOCK_B;
          w_lockChNext = CH_B;
        end else begin
          w_lockChNext = CH_NONE;
        end
      end
      LOCK_A, LOCK_B: begin
        if (w_ownFault) begin
          w_stateNext  = IDLE;
          w_lockChNext = CH_NONE;
        end else if (tx_busy) begin
          w_stateNext = TX;
        end else if (w_othEligible && (r_superCnt == SUPER_LAST)) begin
          w_stateNext  = w_lockA ? LOCK_B : LOCK_A;
          w_lockChNext = w_lockA ? CH_B : CH_A;
          w_abortNext  = 1'b1;
        end else if (!w_ownAct && (r_idleCnt == IDLE_LAST)) begin
          w_stateNext  = IDLE;
          w_lockChNext = CH_NONE;
        end else begin
          if (!w_ownAct) begin
            w_idleCntNext = (r_idleCnt != IDLE_MAX) ? r_idleCnt + IDLE_W'(1) : r_idleCnt;
          end
          if (w_othEligible) begin
            w_superCntNext = (r_superCnt != SUPER_MAX) ? r_superCnt + SUPER_W'(1) : r_superCnt;
          end
        end
      end
      TX: begin
        if (!tx_busy) begin
          w_stateNext = HOLD;
        end
      end
      HOLD: begin
        if (tx_busy) begin
          w_stateNext = TX;
        end else if (r_holdCnt == HOLD_LAST) begin
          if (w_ownFault) begin
            w_stateNext  = IDLE;
            w_lockChNext = CH_NONE;
          end else begin
            w_stateNext = w_lockA ? LOCK_A : LOCK_B;
          end
        end else begin
          w_holdCntNext = r_holdCnt + HOLD_W'(1);
        end
      end
      default: begin
        w_stateNext  = IDLE;
        w_lockChNext = CH_NONE;
      end
    endcase
  end

  logic w_txPhase, w_txA, w_txB;

  assign w_txPhase = (r_state == TX) || (r_state == HOLD);
  assign w_txA     = w_txPhase && (r_lockCh == CH_A);
  assign w_txB     = w_txPhase && (r_lockCh == CH_B);

  assign DO1A         = w_txA & DO1;
  assign DO0A         = w_txA & DO0;
  assign DO1B         = w_txB & DO1;
  assign DO0B         = w_txB & DO0;
  assign TX_INHIBIT_A = !w_txA;
  assign TX_INHIBIT_B = !w_txB;
  assign RX_STROB_A   = !w_txA;
  assign RX_STROB_B   = !w_txB;

  assign DI1 = (r_lockCh == CH_A) ? w_di1A : ((r_lockCh == CH_B) ? w_di1B : 1'b0);
  assign DI0 = (r_lockCh == CH_A) ? w_di0A : ((r_lockCh == CH_B) ? w_di0B : 1'b0);

  assign active_ch  = r_lockCh;
  assign abort      = r_abort;
  assign ch_fault_a = w_faultA;
  assign ch_fault_b = w_faultB;

endmodule

// File: doc/mkio_bus_arbiter.md
MKIO_BUS_ARBITER -- requirements
Module: mkio_bus_arbiter

Interface
REQ-001 Parameters SHALL be: IDLE_TO, 64, consecutive clk32 cycles of locked-channel inactivity before lock release; HOLD_CYC, 10, post-transmit guard cycles; SUPER_CYC, 16, consecutive other-channel activity cycles that supersede the lock; BABBLE_CYC, 25600, continuous-activity fault threshold.
REQ-002 Ports SHALL be: clk32 in 1 clock; reset in 1, asynchronous, active-high.
REQ-003 DI1A, DI0A, DI1B, DI0B in 1 each, raw line inputs; DI1, DI0 out 1 each, selected stream to the receiver.
REQ-004 DO1, DO0 in 1 each, from the transmitter; tx_busy in 1, transmitter busy.
REQ-005 DO1A, DO0A, DO1B, DO0B out 1 each; TX_INHIBIT_A/B out 1 each (1 = inhibited); RX_STROB_A/B out 1 each (1 = receive enabled).
REQ-006 active_ch out 2, 00 none, 01 A, 10 B; abort out 1, one-cycle pulse; ch_fault_a, ch_fault_b out 1 each; fault_clr in 1.

Function
REQ-007 Each DIxy SHALL pass a 2-flop synchronizer; channel activity = synced DI1 | synced DI0.
REQ-008 FSM states SHALL be IDLE, LOCK_A, LOCK_B, TX, HOLD; TX and HOLD retain the locked channel in a register.
REQ-009 IDLE: activity on A -> LOCK_A; else activity on B -> LOCK_B; simultaneous first activity -> LOCK_A; a faulted channel is not eligible.
REQ-010 DI1/DI0 SHALL equal the synced pair of the locked channel; both 0 in IDLE.
REQ-011 LOCK_x: idle counter increments each cycle the locked channel is inactive and clears on activity; at IDLE_TO -> IDLE.
REQ-012 LOCK_x: other channel active SUPER_CYC consecutive cycles -> switch lock to it, pulse abort for 1 cycle, clear the idle counter.
REQ-013 LOCK_x with tx_busy=1 -> TX; supersede and idle timeout are disabled in TX and HOLD.
REQ-014 TX: DO1/DO0 SHALL route to the locked channel only, other channel DO outputs 0; TX_INHIBIT_x=0 and RX_STROB_x=0 for the locked channel; the other channel keeps 1/1.
REQ-015 tx_busy falling -> HOLD for exactly HOLD_CYC cycles with TX/RX control unchanged, then -> LOCK_x with the idle counter cleared.
REQ-016 tx_busy rising in HOLD -> TX without leaving the lock.
REQ-017 Outside TX and HOLD, all DO outputs SHALL be 0, both TX_INHIBIT 1, both RX_STROB 1.
REQ-018 Counters SHALL saturate and never wrap; widths = $clog2(param+1).
REQ-019 tx_busy in IDLE SHALL be ignored and outputs stay inhibited.

Reset
REQ-020 Asynchronous reset SHALL force IDLE, clear counters and synchronizers, active_ch=00, abort=0, faults=0, DO outputs 0, TX_INHIBIT 1, RX_STROB 1.
REQ-021 Reset mid-TX SHALL inhibit both transmitters immediately, without waiting for a clock edge.

Configuration
REQ-022 With MKIO_CH_FAULT_EN defined: per-channel counter of continuous activity; at BABBLE_CYC set sticky ch_fault_x; a faulted locked channel -> IDLE (or, if in TX, after HOLD completes); fault_clr or reset clears the fault.
REQ-023 Without MKIO_CH_FAULT_EN: no babble counters, ch_fault_a/b tied 0, fault_clr ignored.

Structure
REQ-024 Package mkio_pkg SHALL hold the arb_state_t enum, the ch_sel_t enum (NONE/A/B), and the parameter defaults.
REQ-025 Sub-module mkio_act_det (synchronizer, activity, babble counter) SHALL be instantiated once per channel.

Verification
REQ-026 A active at cycle 0 -> active_ch=01 by cycle 3; DI1/DI0 follow A with 2-cycle latency.
REQ-027 A and B rise in the same cycle -> LOCK_A; B held 16 cycles -> active_ch=10 and one abort pulse.
REQ-028 Lock A, tx_busy high 40 cycles -> DO1A/DO0A mirror DO1/DO0, DO1B/DO0B=0, TX_INHIBIT_A=0 until 10 cycles after tx_busy falls.
REQ-029 Lock B, no activity 64 cycles -> IDLE, active_ch=00.
REQ-030 Reset asserted mid-TX -> TX_INHIBIT_A/B=1 same cycle, state IDLE.
REQ-031 With MKIO_CH_FAULT_EN, B active 25600 cycles -> ch_fault_b=1, B ignored in IDLE; fault_clr -> B eligible again.
